// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared DAQ constants, header layout and serializer state type
package daq_pkg;

   localparam int DEF_N_CH      = 16;
   localparam int DEF_N_SAMPLES = 64;
   localparam int DEF_DATA_W    = 32;
   localparam int WORDS_PER_CH  = DEF_N_SAMPLES / DEF_DATA_W;

   localparam logic [7:0] HDR_MAGIC    = 8'hEA;
   localparam logic [7:0] HDR_MAGIC_TS = 8'hEB;

   // Header word layout: [31:24] magic, [23:16] channel count, [15:0] event id
   localparam int HDR_MAGIC_LSB = 24;
   localparam int HDR_NCH_LSB   = 16;
   localparam int HDR_ID_LSB    = 0;
   localparam int HDR_ID_W      = 16;

   typedef enum logic [1:0] {IDLE, HEADER, TSTAMP, PAYLOAD} ser_state_t;

   function automatic logic [31:0] make_header(input logic [7:0]  magic,
                                               input logic [7:0]  n_ch,
                                               input logic [15:0] id);
      logic [31:0] h;
      h = '0;
      h[HDR_MAGIC_LSB +: 8]      = magic;
      h[HDR_NCH_LSB +: 8]        = n_ch;
      h[HDR_ID_LSB +: HDR_ID_W]  = id;
      return h;
   endfunction

endpackage

// File: rtl/event_serializer.sv
// rtl/event_serializer.sv - captures an event snapshot and streams it as a framed word stream (option: EVENT_SERIALIZER_TIMESTAMP_EN)
module event_serializer
   import daq_pkg::*;
#(
   parameter int N_CH      = DEF_N_CH,
   parameter int N_SAMPLES = DEF_N_SAMPLES,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic                              event_valid,
   input  logic [N_CH-1:0][N_SAMPLES-1:0]    event_data,
   output logic                              event_saved,
   output logic [DATA_W-1:0]                 m_tdata,
   output logic                              m_tvalid,
   input  logic                              m_tready,
   output logic                              m_tlast,
   output logic                              busy
);

   localparam int         N_WORDS  = N_CH * (N_SAMPLES / DATA_W);
   localparam int         SEL_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);
`ifdef EVENT_SERIALIZER_TIMESTAMP_EN
   localparam logic [7:0] MAGIC    = HDR_MAGIC_TS;
`else
   localparam logic [7:0] MAGIC    = HDR_MAGIC;
`endif

   ser_state_t state;
   logic       armed;
   logic [15:0] event_id;
   logic [5:0]  word_idx;

   // Viewing the snapshot as a flat word array puts ch0 low, ch0 high, ch1 low ...
   // at consecutive indices, which is exactly the payload order.
   logic [N_WORDS-1:0][DATA_W-1:0] shadow;

   logic               capture;
   logic               hs;
   logic [SEL_W-1:0]   word_sel;
   logic [DATA_W-1:0]  next_word;

   assign capture = (state == IDLE) && event_valid && armed;
   assign hs      = m_tvalid && m_tready;
   assign busy    = (state != IDLE);

   // Payload word mux: the word to present after the current handshake
   always_comb begin
      word_sel  = (state == PAYLOAD) ? SEL_W'(word_idx + 6'd1) : '0;
      next_word = shadow[word_sel];
   end

   // Shadow buffer load on the capture edge; contents need no reset
   always_ff @(posedge clk) begin
      if (capture) begin
         shadow <= event_data;
      end
   end

`ifdef EVENT_SERIALIZER_TIMESTAMP_EN
   logic [31:0] ts_cnt;
   logic [31:0] ts_lat;

   // Free-running cycle counter, sampled when a snapshot is captured
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ts_cnt <= '0;
         ts_lat <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (capture) begin
            ts_lat <= ts_cnt;
         end
      end
   end
`endif

   // Frame sequencer with registered stream outputs and capture handshake
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= IDLE;
         armed       <= 1'b1;
         event_id    <= '0;
         word_idx    <= '0;
         event_saved <= 1'b0;
         m_tvalid    <= 1'b0;
         m_tlast     <= 1'b0;
         m_tdata     <= '0;
      end else begin
         event_saved <= 1'b0;
         // Re-arm only once the sampler has released its request
         if (!event_valid) begin
            armed <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (capture) begin
                  armed       <= 1'b0;
                  event_saved <= 1'b1;
                  m_tvalid    <= 1'b1;
                  m_tlast     <= 1'b0;
                  m_tdata     <= DATA_W'(make_header(MAGIC, 8'(N_CH), event_id));
                  state       <= HEADER;
               end
            end
            HEADER: begin
               if (hs) begin
`ifdef EVENT_SERIALIZER_TIMESTAMP_EN
                  m_tdata  <= DATA_W'(ts_lat);
                  state    <= TSTAMP;
`else
                  word_idx <= '0;
                  m_tdata  <= next_word;
                  m_tlast  <= (LAST_IDX == 6'd0);
                  state    <= PAYLOAD;
`endif
               end
            end
`ifdef EVENT_SERIALIZER_TIMESTAMP_EN
            TSTAMP: begin
               if (hs) begin
                  word_idx <= '0;
                  m_tdata  <= next_word;
                  m_tlast  <= (LAST_IDX == 6'd0);
                  state    <= PAYLOAD;
               end
            end
`endif
            PAYLOAD: begin
               if (hs) begin
                  if (word_idx == LAST_IDX) begin
                     event_id <= event_id + 16'd1;
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     m_tdata  <= '0;
                     state    <= IDLE;
                  end else begin
                     word_idx <= word_idx + 6'd1;
                     m_tdata  <= next_word;
                     m_tlast  <= ((word_idx + 6'd1) == LAST_IDX);
                  end
               end
            end
            default: begin
               m_tvalid <= 1'b0;
               m_tlast  <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_event_serializer.sv
// tb/tb_event_serializer.sv - scoreboard bench for event_serializer (honours EVENT_SERIALIZER_TIMESTAMP_EN)
`timescale 1ns/1ps
module tb_event_serializer;

`ifdef EVENT_SERIALIZER_TIMESTAMP_EN
   localparam int         NW    = 34;
   localparam logic [7:0] MAGIC = 8'hEB;
`else
   localparam int         NW    = 33;
   localparam logic [7:0] MAGIC = 8'hEA;
`endif
   localparam int HDR_WORDS = NW - 32;

   logic              clk = 1'b0;
   logic              aresetn = 1'b0;
   logic              event_valid = 1'b0;
   logic [15:0][63:0] event_data = '0;
   logic              m_tready = 1'b1;
   logic              event_saved;
   logic [31:0]       m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic              busy;

   int          vectors = 0;
   int          miscompares = 0;
   logic [32:0] sb[$];
   logic [15:0] exp_id = 16'h0000;
   logic [31:0] tb_ts;
   int          frame_words = 0;
   logic        prev_stall = 1'b0;
   logic        prev_lasths = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;
   logic [32:0] mon_exp;

   event_serializer dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .event_valid (event_valid),
      .event_data  (event_data),
      .event_saved (event_saved),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tlast     (m_tlast),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) tb_ts <= '0;
      else          tb_ts <= tb_ts + 32'd1;
   end

   // Stream monitor: scoreboard pops, stall stability, inter-frame gap
   always @(negedge clk) begin
      if (!aresetn) begin
         prev_stall  = 1'b0;
         prev_lasths = 1'b0;
         frame_words = 0;
      end else begin
         if (prev_stall) begin
            vectors++;
            if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
               miscompares++;
               $display("FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                        m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
            end
         end
         if (prev_lasths) begin
            vectors++;
            if (m_tvalid !== 1'b0) begin
               miscompares++;
               $display("FAIL idle_gap: got m_tvalid=%b, required 0", m_tvalid);
            end
         end
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_word: got %h, required no word", m_tdata);
            end else begin
               mon_exp = sb.pop_front();
               if (m_tdata !== mon_exp[31:0]) begin
                  miscompares++;
                  $display("FAIL word_data[%0d]: got %h, required %h", frame_words, m_tdata, mon_exp[31:0]);
               end
               vectors++;
               if (m_tlast !== mon_exp[32]) begin
                  miscompares++;
                  $display("FAIL word_last[%0d]: got %b, required %b", frame_words, m_tlast, mon_exp[32]);
               end
            end
            frame_words = (m_tlast === 1'b1) ? 0 : frame_words + 1;
         end
         prev_stall  = (m_tvalid === 1'b1) && (m_tready === 1'b0);
         prev_lasths = (m_tvalid === 1'b1) && (m_tready === 1'b1) && (m_tlast === 1'b1);
         prev_data   = m_tdata;
         prev_last   = m_tlast;
      end
   end

   // Raise event_valid while the DUT is idle and armed; capture lands on the next edge
   task automatic start_event(input logic [15:0][63:0] d);
      @(posedge clk); #1;
      event_data  = d;
      event_valid = 1'b1;
      sb.push_back({1'b0, MAGIC, 8'h10, exp_id});
`ifdef EVENT_SERIALIZER_TIMESTAMP_EN
      sb.push_back({1'b0, tb_ts});
`endif
      for (int k = 0; k < 32; k++) begin
         sb.push_back({(k == 31), d[k / 2][(k % 2) * 32 +: 32]});
      end
      exp_id = exp_id + 16'd1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && m_tvalid === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [15:0][63:0] pattern_data();
      logic [15:0][63:0] d;
      for (int i = 0; i < 16; i++) begin
         d[i][31:0]  = 32'(i << 16);
         d[i][63:32] = 32'((i << 16) | 1);
      end
      return d;
   endfunction

   function automatic logic [15:0][63:0] random_data();
      logic [15:0][63:0] d;
      for (int i = 0; i < 16; i++) d[i] = {$urandom(), $urandom()};
      return d;
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({event_saved, m_tvalid, m_tlast, busy} !== 4'b0000 || m_tdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_values: got saved=%b valid=%b last=%b busy=%b data=%h, required all 0",
                  event_saved, m_tvalid, m_tlast, busy, m_tdata);
      end
      @(posedge clk); #1;
      aresetn = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL after_release: got busy=%b valid=%b, required 0 0", busy, m_tvalid);
      end
   endtask

   task automatic test_frame();
      bit ok;
      start_event(pattern_data());
      @(negedge clk);
      vectors++;
      if (event_saved !== 1'b0) begin
         miscompares++;
         $display("FAIL saved_early: got %b, required 0", event_saved);
      end
      @(negedge clk);
      vectors++;
      if (event_saved !== 1'b1 || m_tvalid !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL saved_pulse: got saved=%b valid=%b busy=%b, required 1 1 1", event_saved, m_tvalid, busy);
      end
      @(negedge clk);
      vectors++;
      if (event_saved !== 1'b0) begin
         miscompares++;
         $display("FAIL saved_width: got %b, required 0", event_saved);
      end
      @(posedge clk); #1;
      event_valid = 1'b0;
      wait_idle(ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL frame_done: got timeout with %0d words pending, required frame end", sb.size());
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      ok = 1'b0;
      start_event(random_data());
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && m_tvalid === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
         m_tready = (c % 4 == 0) || (c % 4 == 3);
         if (c == 2) event_valid = 1'b0;
      end
      @(posedge clk); #1;
      m_tready = 1'b1;
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure_done: got timeout with %0d words pending, required frame end", sb.size());
      end
   endtask

   task automatic test_hold_valid();
      bit ok;
      int pulses;
      pulses = 0;
      start_event(pattern_data());
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         if (event_saved === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 1 || sb.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_single: got pulses=%0d pending=%0d busy=%b, required 1 0 0", pulses, sb.size(), busy);
      end
      @(posedge clk); #1;
      event_valid = 1'b0;
      start_event(random_data());
      @(posedge clk); #1;
      @(posedge clk); #1;
      event_valid = 1'b0;
      wait_idle(ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL rearm_frame: got timeout with %0d words pending, required frame end", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit seen;
      seen = 1'b0;
      start_event(random_data());
      @(posedge clk); #1;
      @(posedge clk); #1;
      event_valid = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (m_tvalid === 1'b1 && m_tlast === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      vectors++;
      if (seen !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_last: got no tlast, required tlast on word %0d", NW);
      end
      start_event(pattern_data());
      @(posedge clk); #1;
      @(posedge clk); #1;
      event_valid = 1'b0;
      wait_idle(ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_done: got timeout with %0d words pending, required frame end", sb.size());
      end
   endtask

   task test_id_wrap();
      bit ok;
      @(posedge clk); #1;
      force dut.event_id = 16'hFFFF;
      @(posedge clk); #1;
      release dut.event_id;
      exp_id = 16'hFFFF;
      for (int f = 0; f < 2; f++) begin
         start_event(random_data());
         @(posedge clk); #1;
         @(posedge clk); #1;
         event_valid = 1'b0;
         wait_idle(ok);
         vectors++;
         if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_frame%0d: got timeout with %0d words pending, required frame end", f, sb.size());
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      bit hit;
      hit = 1'b0;
      start_event(pattern_data());
      @(posedge clk); #1;
      @(posedge clk); #1;
      event_valid = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (frame_words == HDR_WORDS + 10) begin
            hit = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      vectors++;
      if (hit !== 1'b1 || m_tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL reach_word10: got hit=%b valid=%b, required 1 1", hit, m_tvalid);
      end
      aresetn = 1'b0;
      #1;
      vectors++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset: got valid=%b busy=%b last=%b data=%h, required 0 0 0 0",
                  m_tvalid, busy, m_tlast, m_tdata);
      end
      sb.delete();
      exp_id = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      aresetn = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL no_resume: got busy=%b valid=%b, required 0 0", busy, m_tvalid);
      end
      start_event(random_data());
      @(posedge clk); #1;
      @(posedge clk); #1;
      event_valid = 1'b0;
      wait_idle(ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_frame: got timeout with %0d words pending, required frame end", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_backpressure();
      test_hold_valid();
      test_back_to_back();
      test_id_wrap();
      test_reset_mid_frame();
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1);
   end

endmodule
